// File: rtl/spi_sync_target.sv
// Oversampled SPI mode-0 target, MSB first, fully in the clock_i domain.
// Optional SPI_SYNC_TARGET_SDO_TRISTATE_EN: spi_sd_o floats while CS is inactive.
module spi_sync_target #(
  parameter int DATA_WIDTH  = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clock_i,
  input  logic                  reset_ni,
  input  logic                  spi_cs_ni,
  input  logic                  spi_sck_i,
  input  logic                  spi_sd_i,
  output logic                  spi_sd_o,
  input  logic [DATA_WIDTH-1:0] data_i,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  strobe_o,
  output logic                  start_o,
  output logic                  stop_o,
  output logic                  cs_active_o
);
  localparam int CW = (DATA_WIDTH > 2) ? $clog2(DATA_WIDTH) : 1;

  logic [SYNC_STAGES-1:0] cs_sync, sck_sync, sdi_sync;
  logic                   cs_hist, sck_hist;
  logic [CW-1:0]          bit_cnt;
  logic [DATA_WIDTH-2:0]  rx_q;
  logic [DATA_WIDTH-1:0]  tx_q;
  logic                   word_done;

  // CS idles high and SCK idles low, so reset release on an idle bus is silent
  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      cs_sync  <= '1;
      sck_sync <= '0;
      sdi_sync <= '0;
      cs_hist  <= 1'b1;
      sck_hist <= 1'b0;
    end else begin
      cs_sync  <= {cs_sync[SYNC_STAGES-2:0], spi_cs_ni};
      sck_sync <= {sck_sync[SYNC_STAGES-2:0], spi_sck_i};
      sdi_sync <= {sdi_sync[SYNC_STAGES-2:0], spi_sd_i};
      cs_hist  <= cs_sync[SYNC_STAGES-1];
      sck_hist <= sck_sync[SYNC_STAGES-1];
    end
  end

  logic cs_s, sck_s, sdi_s;
  logic cs_fall, cs_rise, sck_rise, sck_fall, in_word;
  logic [DATA_WIDTH-1:0] rx_next;

  assign cs_s     = cs_sync[SYNC_STAGES-1];
  assign sck_s    = sck_sync[SYNC_STAGES-1];
  assign sdi_s    = sdi_sync[SYNC_STAGES-1];
  assign cs_fall  = ~cs_s & cs_hist;
  assign cs_rise  = cs_s & ~cs_hist;
  assign sck_rise = sck_s & ~sck_hist;
  assign sck_fall = ~sck_s & sck_hist;
  // Active and steady: any CS edge this cycle masks SCK edges
  assign in_word  = ~cs_s & ~cs_hist;
  assign rx_next  = {rx_q, sdi_s};

  assign start_o     = cs_fall;
  assign stop_o      = cs_rise;
  assign cs_active_o = ~cs_hist;

  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      bit_cnt   <= '0;
      rx_q      <= '0;
      tx_q      <= '0;
      word_done <= 1'b0;
      data_o    <= '0;
      strobe_o  <= 1'b0;
    end else begin
      strobe_o <= 1'b0;
      if (cs_fall) begin
        bit_cnt   <= '0;
        tx_q      <= data_i;
        word_done <= 1'b0;
      end else if (cs_rise) begin
        bit_cnt   <= '0;
        tx_q      <= '0;
        word_done <= 1'b0;
      end else if (in_word) begin
        if (sck_rise) begin
          rx_q <= rx_next[DATA_WIDTH-2:0];
          if (bit_cnt == CW'(DATA_WIDTH-1)) begin
            bit_cnt   <= '0;
            data_o    <= rx_next;
            strobe_o  <= 1'b1;
            word_done <= 1'b1;
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end else if (sck_fall) begin
          // First fall after a completed word is the reply load point
          if (word_done) begin
            tx_q      <= data_i;
            word_done <= 1'b0;
          end else begin
            tx_q <= {tx_q[DATA_WIDTH-2:0], 1'b0};
          end
        end
      end
    end
  end

`ifdef SPI_SYNC_TARGET_SDO_TRISTATE_EN
  assign spi_sd_o = cs_active_o ? tx_q[DATA_WIDTH-1] : 1'bz;
`else
  assign spi_sd_o = cs_active_o & tx_q[DATA_WIDTH-1];
`endif

endmodule

// File: tb/tb_spi_sync_target.sv
// Scoreboard bench for spi_sync_target: MCU-side SPI driver plus strobe monitor.
module tb_spi_sync_target;
  logic       clock_i = 1'b0;
  logic       reset_ni, spi_cs_ni, spi_sck_i, spi_sd_i;
  logic       spi_sd_o, strobe_o, start_o, stop_o, cs_active_o;
  logic [7:0] data_i, data_o;

  int tests = 0, fails = 0;
  int n_start = 0, n_stop = 0, n_strobe = 0;
  logic [7:0] exp_q[$];

  spi_sync_target #(.DATA_WIDTH(8), .SYNC_STAGES(2)) dut (
    .clock_i(clock_i), .reset_ni(reset_ni), .spi_cs_ni(spi_cs_ni),
    .spi_sck_i(spi_sck_i), .spi_sd_i(spi_sd_i), .spi_sd_o(spi_sd_o),
    .data_i(data_i), .data_o(data_o), .strobe_o(strobe_o),
    .start_o(start_o), .stop_o(stop_o), .cs_active_o(cs_active_o)
  );

  always #5 clock_i = ~clock_i;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endfunction

  task automatic chk_sdo_idle(string name);
    tests++;
`ifdef SPI_SYNC_TARGET_SDO_TRISTATE_EN
    if (spi_sd_o !== 1'bz) begin
      fails++;
      $display("FAIL %s: got %b, expected z", name, spi_sd_o);
    end
`else
    if (spi_sd_o !== 1'b0) begin
      fails++;
      $display("FAIL %s: got %b, expected 0", name, spi_sd_o);
    end
`endif
  endtask

  // Monitor: every strobe pops one expected word from the scoreboard
  always @(negedge clock_i) begin
    if (reset_ni) begin
      if (start_o) n_start++;
      if (stop_o)  n_stop++;
      if (strobe_o) begin
        n_strobe++;
        if (exp_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL strobe_unexpected: got data_o=%0h, expected no strobe", data_o);
        end else begin
          chk("strobe_data", {24'd0, data_o}, {24'd0, exp_q.pop_front()});
        end
      end
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clock_i);
  endtask

  task automatic cs_lo();
    spi_cs_ni = 1'b0;
    cycles(2);
    chk("start_pulse", {31'd0, start_o}, 32'd1);
    cycles(2);
  endtask

  task automatic cs_hi();
    cycles(2);
    spi_cs_ni = 1'b1;
    cycles(2);
    chk("stop_pulse", {31'd0, stop_o}, 32'd1);
    cycles(2);
    chk_sdo_idle("sdo_idle");
  endtask

  // Mode 0 at clock/8: SDI set while SCK low, SDO sampled just before the rise
  task automatic spi_bits(input logic [7:0] tx, input int n, output logic [7:0] rx);
    rx = 8'h00;
    for (int i = 7; i > 7 - n; i--) begin
      spi_sd_i = tx[i];
      cycles(4);
      rx[i] = spi_sd_o;
      spi_sck_i = 1'b1;
      cycles(4);
      spi_sck_i = 1'b0;
    end
  endtask

  initial begin
    logic [7:0] rx1, rx2;
    reset_ni = 1'b0; spi_cs_ni = 1'b1; spi_sck_i = 1'b0; spi_sd_i = 1'b0; data_i = 8'h00;
    cycles(3);
    chk("reset_data_o", {24'd0, data_o}, 32'h0);
    chk("reset_strobe", {31'd0, strobe_o}, 32'd0);
    chk("reset_cs_active", {31'd0, cs_active_o}, 32'd0);
    chk_sdo_idle("reset_sdo");

    reset_ni = 1'b1;
    cycles(20);
    chk("idle_pulses", n_start + n_stop + n_strobe, 32'd0);
    chk("idle_data_o", {24'd0, data_o}, 32'h0);

    // Single word with reply
    data_i = 8'h3C;
    cs_lo();
    chk("cs_active", {31'd0, cs_active_o}, 32'd1);
    exp_q.push_back(8'hA5);
    spi_bits(8'hA5, 8, rx1);
    chk("sdo_word_3c", {24'd0, rx1}, 32'h3C);
    cs_hi();
    chk("strobes_after_a5", n_strobe, 32'd1);
    chk("data_o_a5", {24'd0, data_o}, 32'hA5);

    // Two back-to-back words, reply reloaded at the word boundary
    data_i = 8'h69;
    cs_lo();
    exp_q.push_back(8'h81);
    spi_bits(8'h81, 8, rx1);
    data_i = 8'hF0;
    exp_q.push_back(8'h7E);
    spi_bits(8'h7E, 8, rx2);
    chk("sdo_word1_69", {24'd0, rx1}, 32'h69);
    chk("sdo_word2_f0", {24'd0, rx2}, 32'hF0);
    cs_hi();
    chk("data_o_7e", {24'd0, data_o}, 32'h7E);

    // Abort after 5 bits, then a full word from a fresh counter
    data_i = 8'h00;
    cs_lo();
    spi_bits(8'hFF, 5, rx1);
    cs_hi();
    chk("abort_data_o", {24'd0, data_o}, 32'h7E);
    chk("abort_strobes", n_strobe, 32'd3);
    cs_lo();
    exp_q.push_back(8'h55);
    spi_bits(8'h55, 8, rx1);
    cs_hi();
    chk("data_o_55", {24'd0, data_o}, 32'h55);

    // SCK activity with CS high is ignored
    for (int i = 0; i < 12; i++) begin
      spi_sd_i = i[0];
      spi_sck_i = ~spi_sck_i;
      cycles(4);
    end
    spi_sck_i = 1'b0;
    cycles(4);
    chk("cs_high_strobes", n_strobe, 32'd4);
    data_i = 8'hA5;
    cs_lo();
    exp_q.push_back(8'h96);
    spi_bits(8'h96, 8, rx1);
    chk("sdo_word_a5", {24'd0, rx1}, 32'hA5);
    cs_hi();

    // Reset mid-word: no resume, next transfer starts clean
    cs_lo();
    spi_bits(8'hF0, 4, rx1);
    reset_ni = 1'b0;
    spi_cs_ni = 1'b1;
    cycles(3);
    chk("midreset_data_o", {24'd0, data_o}, 32'h0);
    chk_sdo_idle("midreset_sdo");
    reset_ni = 1'b1;
    cycles(6);
    data_i = 8'h5A;
    cs_lo();
    exp_q.push_back(8'hC3);
    spi_bits(8'hC3, 8, rx1);
    chk("sdo_word_5a", {24'd0, rx1}, 32'h5A);
    cs_hi();
    chk("data_o_c3", {24'd0, data_o}, 32'hC3);

    cycles(4);
    chk("scoreboard_empty", exp_q.size(), 32'd0);
    chk("total_strobes", n_strobe, 32'd6);
    chk("total_starts", n_start, 32'd7);
    chk("total_stops", n_stop, 32'd6);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
